// File: rtl/shift_seq_if.sv
// Request/result bundle for the multi-cycle shift sequencer.
interface shift_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output op,
        output a,
        output b,
        input  r,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        output r,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_seq.sv
// 16-bit shift sequencer: sll/srl/sra/rol, one bit position per clock.
module shift_seq (
    input  logic        clk,
    input  logic        reset,
    shift_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [1:0]  r_opq;
    logic        r_busy;
    logic        r_done;
    logic [15:0] w_step;

    always_comb begin
        w_step = r_acc;
        unique case (r_opq)
            2'b00: w_step = {r_acc[14:0], 1'b0};
            2'b01: w_step = {1'b0, r_acc[15:1]};
            2'b10: w_step = {r_acc[15], r_acc[15:1]};
            2'b11: w_step = {r_acc[14:0], r_acc[15]};
            default: w_step = r_acc;
        endcase
    end

    // busy/done are registered alongside the state so they never glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= 16'h0000;
            r_cnt   <= 4'd0;
            r_opq   <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_acc   <= bus.a;
                        r_cnt   <= bus.b[3:0];
                        r_opq   <= bus.op;
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != 4'd0) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r    = r_acc;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule
